// File: rtl/vsb_burst_arbiter.sv
// Round-robin burst arbiter sharing one VSB write port between NO_OF_CHANNELS requesters,
// with a registered, backpressure-aware output stage.
module vsb_burst_arbiter #(
    parameter int unsigned NO_OF_CHANNELS = 4,
    parameter int unsigned DATAWIDTH      = 32,
    parameter int unsigned ADDRWIDTH      = 16,
    parameter int unsigned MAX_BURST      = 4
) (
    input  logic                                clk,
    input  logic                                nreset,
    input  logic [NO_OF_CHANNELS-1:0]           rqst,
    input  logic [NO_OF_CHANNELS*DATAWIDTH-1:0] vsbdatavec,
    input  logic [NO_OF_CHANNELS*ADDRWIDTH-1:0] vsbaddrvec,
    output logic [NO_OF_CHANNELS-1:0]           ack,
    output logic [DATAWIDTH-1:0]                ivsbdata,
    output logic [ADDRWIDTH-1:0]                ivsbaddr,
    output logic                                ivsbwr,
    input  logic                                ivsbrdy,
    output logic [$clog2(NO_OF_CHANNELS)-1:0]   grant_id,
    output logic                                busy
);

    localparam int unsigned IdW  = $clog2(NO_OF_CHANNELS);
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [IdW-1:0] LastInit = IdW'(NO_OF_CHANNELS - 1);

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    state_e                state_q, state_d;
    logic [IdW-1:0]        last_q, last_d;
    logic [IdW-1:0]        grant_q, grant_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [DATAWIDTH-1:0]  data_q, data_d;
    logic [ADDRWIDTH-1:0]  addr_q, addr_d;

    logic [IdW-1:0]        winner;
    logic [IdW-1:0]        idx;
    logic                  found;
    logic                  can_load;
    logic                  beat_ack;
    logic [DATAWIDTH-1:0]  sel_data;
    logic [ADDRWIDTH-1:0]  sel_addr;

    // Scan last+1 .. last+N so the previous owner is always considered last.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int unsigned i = 1; i <= NO_OF_CHANNELS; i++) begin
            idx = IdW'((32'(last_q) + i) % NO_OF_CHANNELS);
            if (!found && rqst[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign sel_data = vsbdatavec[grant_q*DATAWIDTH +: DATAWIDTH];
    assign sel_addr = vsbaddrvec[grant_q*ADDRWIDTH +: ADDRWIDTH];
    assign can_load = !wr_q || ivsbrdy;
    assign beat_ack = |ack;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= StIdle;
            last_q  <= LastInit;
            grant_q <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|rqst) begin
                    grant_d = winner;
                    cnt_d   = '0;
                    state_d = StOwn;
                end
            end
            StOwn: begin
                if (beat_ack) begin
                    cnt_d = cnt_q + CntW'(1);
                end
                if ((beat_ack && cnt_q == CntW'(MAX_BURST - 1)) || !rqst[grant_q]) begin
                    state_d = StIdle;
                    last_d  = grant_q;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ack = '0;
        if (nreset && state_q == StOwn && rqst[grant_q] && can_load) begin
            ack[grant_q] = 1'b1;
        end
        busy     = (state_q == StOwn);
        grant_id = grant_q;
    end

    // Output register drains independently of the grant state.
    always_comb begin
        wr_d   = wr_q;
        data_d = data_q;
        addr_d = addr_q;
        if (beat_ack) begin
            wr_d   = 1'b1;
            data_d = sel_data;
            addr_d = sel_addr;
        end else if (wr_q && ivsbrdy) begin
            wr_d   = 1'b0;
            data_d = '0;
            addr_d = '0;
        end
    end

    assign ivsbwr   = wr_q;
    assign ivsbdata = data_q;
    assign ivsbaddr = addr_q;

endmodule
